// File: rtl/linebuffer_read_scheduler.sv
// linebuffer_read_scheduler: output-side read controller for the video line-buffer RAM.
// Waits for the capture-side start pulse and locks to the next output frame.
// It then issues a registered read address and read enable for every active output pixel.
// Line-doubler mode reads each buffered line on two output lines.
// Ports:
//   clock, reset_n   pixel clock, asynchronous active-low reset
//   start            single-cycle start pulse from the capture side (already synchronous)
//   line_doubler     1 = each buffered line is read on two consecutive output lines
//   counterX/Y       output raster column / line
//   rdaddr, rden     RAM read address and enable (1-cycle latency from the counters)
//   blank            1 = downstream outputs black instead of RAM data
//   locked           scheduler is in ACTIVE
// Optional: define LOCK_TIMEOUT_EN to drop back to IDLE after MAX_MISSED start-less frames.
module linebuffer_read_scheduler #(
  parameter int ADDR_BITS      = 13,
  parameter int LINE_LENGTH    = 640,
  parameter int RAM_NUMWORDS   = 7680,
  parameter int H_ACTIVE_START = 160,
  parameter int H_ACTIVE_END   = 800,
  parameter int V_ACTIVE_START = 45,
  parameter int V_ACTIVE_END   = 525,
  parameter int MAX_MISSED     = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 line_doubler,
  input  logic [11:0]          counterX,
  input  logic [11:0]          counterY,
  output logic [ADDR_BITS-1:0] rdaddr,
  output logic                 rden,
  output logic                 blank,
  output logic                 locked
);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d, rdaddr_q, rdaddr_d, base_wrap;
  logic phase_q, phase_d, rden_q, rden_d, blank_q, blank_d, locked_q, locked_d;
  logic fs, v_act, ap, line_end;
`ifdef LOCK_TIMEOUT_EN
  localparam int MW = $clog2(MAX_MISSED + 1);
  logic [MW-1:0] missed_q, missed_d;
  logic start_seen_q, start_seen_d;
`endif
  assign fs       = counterX == 12'd0 && counterY == 12'd0;
  assign v_act    = counterY >= 12'(V_ACTIVE_START) && counterY < 12'(V_ACTIVE_END);
  assign ap       = v_act && counterX >= 12'(H_ACTIVE_START) && counterX < 12'(H_ACTIVE_END);
  assign line_end = v_act && counterX == 12'(H_ACTIVE_END);
  assign base_wrap = (32'(base_q) + LINE_LENGTH >= RAM_NUMWORDS) ? '0 : base_q + ADDR_BITS'(LINE_LENGTH);
  always_comb begin
    // Frame start wins over a line advance; in doubler mode the base only moves after the second read.
    base_d   = fs ? '0 : (line_end && (!line_doubler || phase_q)) ? base_wrap : base_q;
    phase_d  = fs ? 1'b0 : (line_end && line_doubler) ? !phase_q : phase_q;
    rden_d   = state_q == ACTIVE && ap;
    blank_d  = !rden_d;
    rdaddr_d = ap ? base_q + ADDR_BITS'(counterX - 12'(H_ACTIVE_START)) : rdaddr_q;
    locked_d = state_d == ACTIVE;
  end
  always_comb begin
    state_d = state_q;
`ifdef LOCK_TIMEOUT_EN
    missed_d     = missed_q;
    start_seen_d = start_seen_q;
`endif
    case (state_q)
      IDLE: state_d = start ? WAIT_FRAME : IDLE;
      WAIT_FRAME: begin
        state_d = fs ? ACTIVE : WAIT_FRAME;
`ifdef LOCK_TIMEOUT_EN
        missed_d     = fs ? '0 : missed_q;
        start_seen_d = fs ? 1'b0 : start_seen_q;
`endif
      end
      ACTIVE: begin
`ifdef LOCK_TIMEOUT_EN
        // A start coinciding with FS belongs to the frame that is just beginning.
        if (fs) begin
          missed_d     = start_seen_q ? '0 : missed_q + 1'b1;
          start_seen_d = start;
          state_d      = missed_d == MW'(MAX_MISSED) ? IDLE : ACTIVE;
        end else if (start) begin
          start_seen_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      phase_q  <= 1'b0;
      rdaddr_q <= '0;
      rden_q   <= 1'b0;
      blank_q  <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      phase_q  <= phase_d;
      rdaddr_q <= rdaddr_d;
      rden_q   <= rden_d;
      blank_q  <= blank_d;
      locked_q <= locked_d;
    end
  end
`ifdef LOCK_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      missed_q     <= '0;
      start_seen_q <= 1'b0;
    end else begin
      missed_q     <= missed_d;
      start_seen_q <= start_seen_d;
    end
  end
`endif
  assign rdaddr = rdaddr_q;
  assign rden   = rden_q;
  assign blank  = blank_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_linebuffer_read_scheduler.sv
// tb_linebuffer_read_scheduler: randomized sparse-raster bench with a behavioural scheduler model.
module tb_linebuffer_read_scheduler;
  localparam int LL = 640, NW = 7680, NLINES = NW / LL;
  localparam int HS = 160, HE = 800, VS = 45, VE = 525;
  logic clock, reset_n, start, line_doubler;
  logic [11:0] counterX, counterY;
  logic [12:0] rdaddr;
  logic rden, blank, locked;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int a160[VE];
  logic r160_45, b160_45, lock_fs, r800, b800;
  int a799, a800;

  linebuffer_read_scheduler dut (
    .clock(clock), .reset_n(reset_n), .start(start), .line_doubler(line_doubler),
    .counterX(counterX), .counterY(counterY),
    .rdaddr(rdaddr), .rden(rden), .blank(blank), .locked(locked)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Model: st 0=idle 1=waiting for frame 2=active; li counts buffered lines consumed since FS.
  typedef struct packed {
    int st; int li; logic ph; int miss; logic seen;
    logic rden; logic blank; int addr; logic lock;
  } m_t;
  m_t m;

  function automatic m_t m_reset();
    m_t n = '0;
    n.blank = 1;
    return n;
  endfunction

  function automatic m_t step(m_t c, int x, int y, logic s, logic ld);
    m_t n = c;
    logic fs = x == 0 && y == 0;
    logic vact = y >= VS && y < VE;
    logic ap = vact && x >= HS && x < HE;
    n.rden = c.st == 2 && ap;
    n.blank = !n.rden;
    if (ap) n.addr = (c.li % NLINES) * LL + x - HS;
    if (x == HE && vact) begin
      if (!ld || c.ph) n.li = c.li + 1;
      if (ld) n.ph = !c.ph;
    end
    if (fs) begin n.li = 0; n.ph = 0; end
    if (c.st == 0 && s) n.st = 1;
    else if (c.st == 1 && fs) begin n.st = 2; n.miss = 0; n.seen = 0; end
    else if (c.st == 2) begin
      if (fs) begin
`ifdef LOCK_TIMEOUT_EN
        n.miss = c.seen ? 0 : c.miss + 1;
        if (n.miss >= 3) n.st = 0;
`endif
        n.seen = s;
      end else if (s) n.seen = 1;
    end
    n.lock = n.st == 2;
    return n;
  endfunction

  always @(posedge clock or negedge reset_n)
    if (!reset_n) m <= m_reset();
    else m <= step(m, int'(counterX), int'(counterY), start, line_doubler);

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (chk_en) begin
      check("rden", 32'(rden), 32'(m.rden));
      check("blank", 32'(blank), 32'(m.blank));
      check("rdaddr", 32'(rdaddr), 32'(m.addr));
      check("locked", 32'(locked), 32'(m.lock));
    end

  task automatic cyc(int x, int y, logic s);
    counterX = 12'(x);
    counterY = 12'(y);
    start = s;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_line(int y, logic ld, logic s_en);
    line_doubler = ld;
    cyc(0, y, 0);
    if (y == 0) lock_fs = locked;
    if (y == 100 && s_en) cyc(5, y, 1);
    cyc(159, y, 0);
    cyc(160, y, 0);
    a160[y] = int'(rdaddr);
    if (y == VS) begin r160_45 = rden; b160_45 = blank; end
    cyc(161, y, 0);
    repeat (3) cyc($urandom_range(162, 797), y, 0);
    cyc(799, y, 0);
    if (y == VS) a799 = int'(rdaddr);
    cyc(800, y, 0);
    if (y == VS) begin a800 = int'(rdaddr); r800 = rden; b800 = blank; end
    cyc(801, y, 0);
    cyc(900, y, 0);
  endtask

  // ld_mode: 0 / 1 fixed doubler setting, 2 = random per line.
  task automatic do_frame(int ld_mode, logic s_en);
    int ys[$];
    ys = {0, 44};
    for (int y = 45; y <= 60; y++) ys.push_back(y);
    if (ld_mode == 2) for (int k = 0; k < 3; k++) ys.push_back($urandom_range(61, 99));
    ys.push_back(100);
    ys.push_back(200);
    ys.push_back(524);
    foreach (ys[i])
      do_line(ys[i], ld_mode == 2 ? logic'($urandom_range(0, 1)) : logic'(ld_mode), s_en);
  endtask

  initial begin
    reset_n = 0; start = 0; line_doubler = 0; counterX = 0; counterY = 0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_rden", 32'(rden), 0);
    check("reset_blank", 32'(blank), 1);
    check("reset_locked", 32'(locked), 0);
    check("reset_rdaddr", 32'(rdaddr), 0);
    chk_en = 1;
    reset_n = 1;
    do_frame(0, 0);
    do_frame(0, 1);
    check("idle_fs_unlocked", 32'(lock_fs), 0);
    do_frame(0, 1);
    check("lock_after_fs", 32'(lock_fs), 1);
    check("first_px_rden", 32'(r160_45), 1);
    check("first_px_blank", 32'(b160_45), 0);
    check("addr_y45", 32'(a160[45]), 0);
    check("addr_y46", 32'(a160[46]), 640);
    check("addr_y56", 32'(a160[56]), 7040);
    check("addr_y57_wrap", 32'(a160[57]), 0);
    check("addr_x799", 32'(a799), 639);
    check("addr_x800_hold", 32'(a800), 639);
    check("rden_x800", 32'(r800), 0);
    check("blank_x800", 32'(b800), 1);
    do_frame(1, 1);
    check("dbl_y45", 32'(a160[45]), 0);
    check("dbl_y46", 32'(a160[46]), 0);
    check("dbl_y47", 32'(a160[47]), 640);
    check("dbl_y49", 32'(a160[49]), 1280);
    repeat (3) do_frame(0, 0);
    do_frame(0, 1);
`ifdef LOCK_TIMEOUT_EN
    check("lock_lost_3rd_fs", 32'(lock_fs), 0);
`else
    check("lock_kept", 32'(lock_fs), 1);
`endif
    do_frame(0, 1);
    check("relock", 32'(lock_fs), 1);
    cyc(0, 0, 0);
    cyc(300, 50, 0);
    check("pre_reset_rden", 32'(rden), 1);
    #2 reset_n = 0;
    #1;
    check("async_rden", 32'(rden), 0);
    check("async_blank", 32'(blank), 1);
    check("async_rdaddr", 32'(rdaddr), 0);
    @(negedge clock);
    #1 reset_n = 1;
    for (int f = 0; f < 20; f++) do_frame($urandom_range(0, 2), $urandom_range(0, 2) != 0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
